// File: rtl/clock_set_ctrl_if.sv
// Button, live-time and timekeeper-load signals between the clock-set
// controller (slave) and the panel/timekeeper side (master).
interface clock_set_ctrl_if #(
  parameter int P_SEC_BIT  = 6,
  parameter int P_MIN_BIT  = 6,
  parameter int P_HOUR_BIT = 5
);

  logic                  i_btn_mode;
  logic                  i_btn_up;
  logic                  i_btn_down;
  logic                  i_btn_cancel;
  logic [P_SEC_BIT-1:0]  i_sec;
  logic [P_MIN_BIT-1:0]  i_min;
  logic [P_HOUR_BIT-1:0] i_hour;

  logic                  o_run_en;
  logic                  o_load;
  logic [P_SEC_BIT-1:0]  o_ld_sec;
  logic [P_MIN_BIT-1:0]  o_ld_min;
  logic [P_HOUR_BIT-1:0] o_ld_hour;
  logic [2:0]            o_state;

  modport master (
    output i_btn_mode, i_btn_up, i_btn_down, i_btn_cancel,
    output i_sec, i_min, i_hour,
    input  o_run_en, o_load, o_ld_sec, o_ld_min, o_ld_hour, o_state
  );

  modport slave (
    input  i_btn_mode, i_btn_up, i_btn_down, i_btn_cancel,
    input  i_sec, i_min, i_hour,
    output o_run_en, o_load, o_ld_sec, o_ld_min, o_ld_hour, o_state
  );

endinterface

// File: rtl/clock_set_ctrl.sv
// Clock-set controller: captures the live time, lets the user edit hour,
// minute and second in turn, then pulses a one-cycle load to the timekeeper.
module clock_set_ctrl #(
  parameter int P_SEC_BIT  = 6,
  parameter int P_MIN_BIT  = 6,
  parameter int P_HOUR_BIT = 5
) (
  input  logic             clk,
  input  logic             reset,
  clock_set_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_HOUR = 3'd1,
    SET_MIN  = 3'd2,
    SET_SEC  = 3'd3,
    COMMIT   = 3'd4
  } state_t;

  localparam logic [P_HOUR_BIT-1:0] HOUR_MAX = P_HOUR_BIT'(23);
  localparam logic [P_MIN_BIT-1:0]  MIN_MAX  = P_MIN_BIT'(59);
  localparam logic [P_SEC_BIT-1:0]  SEC_MAX  = P_SEC_BIT'(59);
  localparam logic [P_HOUR_BIT-1:0] HOUR_ONE = P_HOUR_BIT'(1);
  localparam logic [P_MIN_BIT-1:0]  MIN_ONE  = P_MIN_BIT'(1);
  localparam logic [P_SEC_BIT-1:0]  SEC_ONE  = P_SEC_BIT'(1);

  state_t                state;
  logic                  run_en;
  logic                  load;
  logic [P_SEC_BIT-1:0]  ld_sec;
  logic [P_MIN_BIT-1:0]  ld_min;
  logic [P_HOUR_BIT-1:0] ld_hour;

  // Wrap by explicit compare so out-of-range captured values also land in range.
  function automatic logic [P_HOUR_BIT-1:0] step_hour(
    input logic [P_HOUR_BIT-1:0] v, input logic inc);
    if (inc)
      return (v >= HOUR_MAX) ? '0 : v + HOUR_ONE;
    else
      return (v == '0 || v > HOUR_MAX) ? HOUR_MAX : v - HOUR_ONE;
  endfunction

  function automatic logic [P_MIN_BIT-1:0] step_min(
    input logic [P_MIN_BIT-1:0] v, input logic inc);
    if (inc)
      return (v >= MIN_MAX) ? '0 : v + MIN_ONE;
    else
      return (v == '0 || v > MIN_MAX) ? MIN_MAX : v - MIN_ONE;
  endfunction

  function automatic logic [P_SEC_BIT-1:0] step_sec(
    input logic [P_SEC_BIT-1:0] v, input logic inc);
    if (inc)
      return (v >= SEC_MAX) ? '0 : v + SEC_ONE;
    else
      return (v == '0 || v > SEC_MAX) ? SEC_MAX : v - SEC_ONE;
  endfunction

  logic edit_step;
  assign edit_step = bus.i_btn_up ^ bus.i_btn_down;

  // Single state machine; cancel beats mode, mode beats up/down.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      run_en  <= 1'b1;
      load    <= 1'b0;
      ld_sec  <= '0;
      ld_min  <= '0;
      ld_hour <= '0;
    end else begin
      load <= 1'b0;
      case (state)
        RUN: begin
          run_en <= 1'b1;
          if (bus.i_btn_mode) begin
            state   <= SET_HOUR;
            run_en  <= 1'b0;
            ld_sec  <= bus.i_sec;
            ld_min  <= bus.i_min;
            ld_hour <= bus.i_hour;
          end
        end

        SET_HOUR, SET_MIN, SET_SEC: begin
          run_en <= 1'b0;
          if (bus.i_btn_cancel) begin
            state  <= RUN;
            run_en <= 1'b1;
          end else if (bus.i_btn_mode) begin
            case (state)
              SET_HOUR: state <= SET_MIN;
              SET_MIN:  state <= SET_SEC;
              default: begin
                state <= COMMIT;
                load  <= 1'b1;
              end
            endcase
          end else if (edit_step) begin
            case (state)
              SET_HOUR: ld_hour <= step_hour(ld_hour, bus.i_btn_up);
              SET_MIN:  ld_min  <= step_min(ld_min, bus.i_btn_up);
              default:  ld_sec  <= step_sec(ld_sec, bus.i_btn_up);
            endcase
          end
        end

        COMMIT: begin
          state  <= RUN;
          run_en <= 1'b1;
        end

        default: begin
          state  <= RUN;
          run_en <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_state   = state;
  assign bus.o_run_en  = run_en;
  assign bus.o_load    = load;
  assign bus.o_ld_sec  = ld_sec;
  assign bus.o_ld_min  = ld_min;
  assign bus.o_ld_hour = ld_hour;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: each stimulus cycle queues the outputs
// expected after the next rising edge; a negedge checker pops and compares.
module tb_clock_set_ctrl;

  localparam logic [2:0] S_RUN = 3'd0;
  localparam logic [2:0] S_SH  = 3'd1;
  localparam logic [2:0] S_SM  = 3'd2;
  localparam logic [2:0] S_SS  = 3'd3;
  localparam logic [2:0] S_CM  = 3'd4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  clock_set_ctrl_if #(.P_SEC_BIT(6), .P_MIN_BIT(6), .P_HOUR_BIT(5)) bus ();

  clock_set_ctrl #(.P_SEC_BIT(6), .P_MIN_BIT(6), .P_HOUR_BIT(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] due;
    logic [2:0]  st;
    logic        run_en;
    logic        load;
    logic [4:0]  hour;
    logic [5:0]  min;
    logic [5:0]  sec;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    cycle = 0;
  int    tests = 0;
  int    fails = 0;
  bit    toggle_live = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    if (obs !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic setLive(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    bus.i_hour = h;
    bus.i_min  = m;
    bus.i_sec  = s;
  endtask

  // One cycle of buttons/reset, plus the outputs expected after the next edge.
  task automatic applyStimulus(input string tag, input logic rst, input logic m,
                               input logic u, input logic d, input logic c,
                               input logic [2:0] st, input logic run_en, input logic load,
                               input logic [4:0] h, input logic [5:0] mi, input logic [5:0] s);
    exp_t e;
    @(negedge clk);
    reset            = rst;
    bus.i_btn_mode   = m;
    bus.i_btn_up     = u;
    bus.i_btn_down   = d;
    bus.i_btn_cancel = c;
    if (toggle_live)
      setLive(5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    e.due    = 32'(cycle + 1);
    e.st     = st;
    e.run_en = run_en;
    e.load   = load;
    e.hour   = h;
    e.min    = mi;
    e.sec    = s;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  initial begin
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= 32'(cycle)) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checkOutput({t, ".state"},  32'(bus.o_state),   32'(e.st));
        checkOutput({t, ".run_en"}, 32'(bus.o_run_en),  32'(e.run_en));
        checkOutput({t, ".load"},   32'(bus.o_load),    32'(e.load));
        checkOutput({t, ".hour"},   32'(bus.o_ld_hour), 32'(e.hour));
        checkOutput({t, ".min"},    32'(bus.o_ld_min),  32'(e.min));
        checkOutput({t, ".sec"},    32'(bus.o_ld_sec),  32'(e.sec));
      end
    end
  end

  initial begin
    bus.i_btn_mode   = 1'b0;
    bus.i_btn_up     = 1'b0;
    bus.i_btn_down   = 1'b0;
    bus.i_btn_cancel = 1'b0;
    setLive(5'd12, 6'd34, 6'd56);

    applyStimulus("reset",    1, 0, 0, 0, 0, S_RUN, 1, 0, 0, 0, 0);
    applyStimulus("rst_ovr",  1, 1, 1, 0, 1, S_RUN, 1, 0, 0, 0, 0);
    applyStimulus("run_up",   0, 0, 1, 0, 0, S_RUN, 1, 0, 0, 0, 0);
    applyStimulus("run_ign",  0, 0, 1, 1, 1, S_RUN, 1, 0, 0, 0, 0);

    applyStimulus("enter",    0, 1, 0, 0, 0, S_SH, 0, 0, 12, 34, 56);
    toggle_live = 1'b1;
    applyStimulus("h_up1",    0, 0, 1, 0, 0, S_SH, 0, 0, 13, 34, 56);
    applyStimulus("h_up2",    0, 0, 1, 0, 0, S_SH, 0, 0, 14, 34, 56);
    applyStimulus("to_min",   0, 1, 0, 0, 0, S_SM, 0, 0, 14, 34, 56);
    applyStimulus("m_dn",     0, 0, 0, 1, 0, S_SM, 0, 0, 14, 33, 56);
    applyStimulus("to_sec",   0, 1, 0, 0, 0, S_SS, 0, 0, 14, 33, 56);
    applyStimulus("s_up1",    0, 0, 1, 0, 0, S_SS, 0, 0, 14, 33, 57);
    applyStimulus("s_up2",    0, 0, 1, 0, 0, S_SS, 0, 0, 14, 33, 58);
    applyStimulus("s_up3",    0, 0, 1, 0, 0, S_SS, 0, 0, 14, 33, 59);
    applyStimulus("s_up4",    0, 0, 1, 0, 0, S_SS, 0, 0, 14, 33, 0);
    applyStimulus("commit",   0, 1, 0, 0, 0, S_CM, 0, 1, 14, 33, 0);
    toggle_live = 1'b0;
    applyStimulus("cm_ign",   0, 1, 1, 1, 1, S_RUN, 1, 0, 14, 33, 0);
    applyStimulus("after",    0, 0, 0, 0, 0, S_RUN, 1, 0, 14, 33, 0);

    setLive(5'd23, 6'd0, 6'd59);
    applyStimulus("w_enter",  0, 1, 0, 0, 0, S_SH, 0, 0, 23, 0, 59);
    applyStimulus("h_wrapup", 0, 0, 1, 0, 0, S_SH, 0, 0, 0, 0, 59);
    applyStimulus("h_wrapdn", 0, 0, 0, 1, 0, S_SH, 0, 0, 23, 0, 59);
    applyStimulus("w_min",    0, 1, 0, 0, 0, S_SM, 0, 0, 23, 0, 59);
    applyStimulus("m_wrapdn", 0, 0, 0, 1, 0, S_SM, 0, 0, 23, 59, 59);
    applyStimulus("w_sec",    0, 1, 0, 0, 0, S_SS, 0, 0, 23, 59, 59);
    applyStimulus("s_wrapup", 0, 0, 1, 0, 0, S_SS, 0, 0, 23, 59, 0);
    applyStimulus("s_updn",   0, 0, 1, 1, 0, S_SS, 0, 0, 23, 59, 0);
    applyStimulus("s_cancel", 0, 0, 0, 0, 1, S_RUN, 1, 0, 23, 59, 0);

    setLive(5'd1, 6'd2, 6'd3);
    applyStimulus("c_enter",  0, 1, 0, 0, 0, S_SH, 0, 0, 1, 2, 3);
    applyStimulus("c_modeup", 0, 1, 1, 0, 0, S_SM, 0, 0, 1, 2, 3);
    applyStimulus("c_updn",   0, 0, 1, 1, 0, S_SM, 0, 0, 1, 2, 3);
    applyStimulus("c_up",     0, 0, 1, 0, 0, S_SM, 0, 0, 1, 3, 3);
    applyStimulus("c_cancel", 0, 1, 0, 0, 1, S_RUN, 1, 0, 1, 3, 3);
    for (int i = 0; i < 20; i++)
      applyStimulus("c_idle", 0, 0, 0, 0, 0, S_RUN, 1, 0, 1, 3, 3);

    setLive(5'd5, 6'd6, 6'd7);
    applyStimulus("d_enter",  0, 1, 0, 0, 0, S_SH, 0, 0, 5, 6, 7);
    applyStimulus("d_min",    0, 1, 0, 0, 0, S_SM, 0, 0, 5, 6, 7);
    applyStimulus("d_sec",    0, 1, 0, 0, 0, S_SS, 0, 0, 5, 6, 7);
    applyStimulus("d_commit", 0, 1, 0, 0, 0, S_CM, 0, 1, 5, 6, 7);
    applyStimulus("d_reset",  1, 0, 0, 0, 0, S_RUN, 1, 0, 0, 0, 0);
    applyStimulus("d_idle",   0, 0, 0, 0, 0, S_RUN, 1, 0, 0, 0, 0);
    applyStimulus("d_idle2",  0, 0, 1, 0, 1, S_RUN, 1, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(negedge clk);
    #1;
    checkOutput("drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter P_SEC_BIT, default 6, width of the seconds fields.
REQ-002 Parameter P_MIN_BIT, default 6, width of the minutes fields.
REQ-003 Parameter P_HOUR_BIT, default 5, width of the hours fields.
REQ-004 clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-005 reset  in  1  reset; synchronous, active-high.
REQ-006 i_btn_mode  in  1  one-cycle pulse; advances the set sequence.
REQ-007 i_btn_up  in  1  one-cycle pulse; increments the field being edited.
REQ-008 i_btn_down  in  1  one-cycle pulse; decrements the field being edited.
REQ-009 i_btn_cancel  in  1  one-cycle pulse; abandons the edit.
REQ-010 i_sec / i_min / i_hour  in  P_SEC_BIT / P_MIN_BIT / P_HOUR_BIT  live time from the timekeeping counter.
REQ-011 o_run_en  out  1  run enable to the timekeeping counter.
REQ-012 o_load  out  1  one-cycle pulse; timekeeper SHALL take the o_ld_* values.
REQ-013 o_ld_sec / o_ld_min / o_ld_hour  out  P_SEC_BIT / P_MIN_BIT / P_HOUR_BIT  edit registers; also drive the display while editing.
REQ-014 o_state  out  3  current FSM state code, for display blanking and status.

Function
REQ-015 States and encoding SHALL be RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3, COMMIT=4; all outputs SHALL be registered.
REQ-016 RUN + i_btn_mode at cycle N: at N+1 SHALL be in SET_HOUR, o_run_en=0, and o_ld_* = i_* sampled at N.
REQ-017 On i_btn_mode, SET_HOUR SHALL go to SET_MIN, SET_MIN to SET_SEC, and SET_SEC to COMMIT.
REQ-018 COMMIT SHALL last exactly one cycle with o_load=1 and o_run_en=0, then go to RUN.
REQ-019 On the cycle after COMMIT: o_load=0 and o_run_en=1.
REQ-020 i_btn_up in SET_x SHALL increment only field x; hour SHALL wrap 23->0, min/sec SHALL wrap 59->0.
REQ-021 i_btn_down in SET_x SHALL decrement only field x; hour SHALL wrap 0->23, min/sec SHALL wrap 0->59.
REQ-022 All edit arithmetic SHALL use an explicit compare against the limit, never natural overflow (e.g. 6b 63 is never reachable).
REQ-023 i_btn_cancel in any SET_x SHALL go to RUN next cycle with o_run_en=1, o_load never asserted, and edit registers unchanged.
REQ-024 Priority on simultaneous pulses SHALL be cancel > mode > up/down.
REQ-025 up and down together, with no higher-priority pulse, SHALL leave the field unchanged.
REQ-026 In RUN, up/down/cancel SHALL be ignored; o_ld_* SHALL hold their last values.
REQ-027 In COMMIT, all button inputs SHALL be ignored.
REQ-028 i_* SHALL be sampled only on the RUN->SET_HOUR transition; live changes during editing SHALL have no effect.
REQ-029 o_load SHALL assert at most once per edit session and never two cycles in a row.

Reset
REQ-030 When reset=1, the next state SHALL be RUN with o_run_en=1, o_load=0, o_ld_sec/o_ld_min/o_ld_hour=0, and o_state=0.
REQ-031 Reset SHALL override all inputs in the same cycle.
REQ-032 Reset asserted in any state, including COMMIT, SHALL abort that state with no o_load pulse emitted.
REQ-033 After reset, no state other than RUN SHALL be entered without an i_btn_mode pulse.

Verification
REQ-034 Full set: i_*=12:34:56, mode -> o_ld=12:34:56 and o_run_en=0; up x2 (hour), mode, down x1 (min), mode, up x4 (sec), mode -> exactly one o_load pulse with o_ld=14:33:00 (sec wraps 56->59->0); o_run_en=1 one cycle after o_load.
REQ-035 Wrap: hour=23, up -> 0; hour=0, down -> 23; min=0, down -> 59; sec=59, up -> 0.
REQ-036 Cancel: in SET_MIN, cancel -> RUN next cycle, o_run_en=1, o_load stays 0 for 20 following cycles.
REQ-037 Simultaneous pulses: mode+up in SET_HOUR -> SET_MIN with hour unchanged; up+down -> no change; cancel+mode -> RUN.
REQ-038 Live input change: i_* toggles every cycle during SET_HOUR/SET_MIN/SET_SEC -> o_ld_* are affected only by buttons.
REQ-039 Reset mid-COMMIT: assert reset in the COMMIT cycle -> o_load=0 next cycle, RUN, all o_ld_*=0, o_run_en=1.
